// File: rtl/commute_calendar_pkg.sv
// Shared calendar/bus-selector types, constants and small decode helpers.
package commute_pkg;

    localparam int HOURS_PER_DAY = 24;
    localparam int DAYS_PER_WEEK = 7;

    typedef logic [2:0] dow_t;

    localparam dow_t SUNDAY    = 3'd0;
    localparam dow_t MONDAY    = 3'd1;
    localparam dow_t TUESDAY   = 3'd2;
    localparam dow_t WEDNESDAY = 3'd3;
    localparam dow_t THURSDAY  = 3'd4;
    localparam dow_t FRIDAY    = 3'd5;
    localparam dow_t SATURDAY  = 3'd6;

    typedef enum logic [1:0] {
        COLOR_RED    = 2'd0,
        COLOR_GREEN  = 2'd1,
        COLOR_BLUE   = 2'd2,
        COLOR_YELLOW = 2'd3
    } bus_color_t;

    function automatic logic [4:0] sat_hour(input logic [4:0] h);
        return (h > 5'd23) ? 5'd23 : h;
    endfunction

    function automatic dow_t sat_dow(input logic [2:0] d);
        return (d == 3'd7) ? SATURDAY : d;
    endfunction

    function automatic logic is_weekday(input dow_t d);
        return (d >= MONDAY) && (d <= FRIDAY);
    endfunction

    function automatic logic is_daytime(input logic [4:0] h, input int day_start, input int day_end);
        return (int'(h) >= day_start) && (int'(h) < day_end);
    endfunction

endpackage

// File: rtl/commute_calendar_if.sv
// Control/status bundle between the calendar and whoever drives and reads it.
interface commute_calendar_if;
    logic       tick;
    logic       load;
    logic [4:0] load_hour;
    logic [2:0] load_dow;
    logic       holiday_set;
    logic       holiday_next;
    logic [4:0] hour;
    logic [2:0] dow;
    logic       daytime;
    logic       weekday;
    logic       holiday;

    modport master (
        output tick, load, load_hour, load_dow, holiday_set, holiday_next,
        input  hour, dow, daytime, weekday, holiday
    );

    modport slave (
        input  tick, load, load_hour, load_dow, holiday_set, holiday_next,
        output hour, dow, daytime, weekday, holiday
    );
endinterface

// File: rtl/commute_calendar_wrap_counter.sv
// Modulo-MOD counter with load; o_wrap flags the increment that returns it to 0,
// so counters chain by feeding o_wrap into the next stage's i_inc.
module wrap_counter #(
    parameter int MOD = 2,
    parameter int W   = (MOD > 1) ? $clog2(MOD) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_inc,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic [W-1:0] o_count,
    output logic [W-1:0] o_count_next,
    output logic         o_wrap
);
    localparam logic [W-1:0] LAST = W'(MOD - 1);

    logic [W-1:0] r_count;

    assign o_count = r_count;
    assign o_wrap  = i_inc & ~i_load & (r_count == LAST);

    always_comb begin
        o_count_next = r_count;
        if (i_load)
            o_count_next = i_load_val;
        else if (i_inc)
            o_count_next = (r_count == LAST) ? '0 : r_count + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_count <= '0;
        else
            r_count <= o_count_next;
    end
endmodule

// File: rtl/commute_calendar.sv
// Time-of-week generator producing registered daytime/weekday/holiday conditions.
// Holiday tracking is built only when COMMUTE_CALENDAR_HOLIDAY_EN is defined.
module commute_calendar
    import commute_pkg::*;
#(
    parameter int TICKS_PER_HOUR = 4,
    parameter int DAY_START      = 7,
    parameter int DAY_END        = 19
) (
    input  logic               clk,
    input  logic               reset,
    commute_calendar_if.slave  bus
);
    localparam int TW = (TICKS_PER_HOUR > 1) ? $clog2(TICKS_PER_HOUR) : 1;

    logic [TW-1:0] w_tick_cnt, w_tick_cnt_next;
    logic          w_tick_wrap;
    logic [4:0]    w_hour, w_hour_next;
    logic          w_hour_wrap;
    logic [2:0]    w_dow, w_dow_next;
    logic          w_dow_wrap;
    logic          w_tick_inc;
    logic          r_daytime, r_weekday;

    // Load wins over tick, so a loading cycle never advances or rolls over.
    assign w_tick_inc = bus.tick & ~bus.load;

    wrap_counter #(.MOD(TICKS_PER_HOUR), .W(TW)) u_tick (
        .clk(clk), .reset(reset),
        .i_inc(w_tick_inc), .i_load(bus.load), .i_load_val('0),
        .o_count(w_tick_cnt), .o_count_next(w_tick_cnt_next), .o_wrap(w_tick_wrap)
    );

    wrap_counter #(.MOD(HOURS_PER_DAY), .W(5)) u_hour (
        .clk(clk), .reset(reset),
        .i_inc(w_tick_wrap), .i_load(bus.load), .i_load_val(sat_hour(bus.load_hour)),
        .o_count(w_hour), .o_count_next(w_hour_next), .o_wrap(w_hour_wrap)
    );

    wrap_counter #(.MOD(DAYS_PER_WEEK), .W(3)) u_dow (
        .clk(clk), .reset(reset),
        .i_inc(w_hour_wrap), .i_load(bus.load), .i_load_val(sat_dow(bus.load_dow)),
        .o_count(w_dow), .o_count_next(w_dow_next), .o_wrap(w_dow_wrap)
    );

    logic w_unused;
    assign w_unused = ^{w_tick_cnt, w_tick_cnt_next, w_dow_wrap};

    // Decoding next-state keeps the registered conditions aligned with hour/dow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_daytime <= 1'b0;
            r_weekday <= 1'b0;
        end else begin
            r_daytime <= is_daytime(w_hour_next, DAY_START, DAY_END);
            r_weekday <= is_weekday(w_dow_next);
        end
    end

    assign bus.hour    = w_hour;
    assign bus.dow     = w_dow;
    assign bus.daytime = r_daytime;
    assign bus.weekday = r_weekday;

`ifdef COMMUTE_CALENDAR_HOLIDAY_EN
    logic r_holiday, r_pending;
    logic w_holiday_nx, w_pending_nx;

    // Set requests are applied after the rollover hand-off so they land on the new day.
    always_comb begin
        w_holiday_nx = r_holiday;
        w_pending_nx = r_pending;
        if (w_hour_wrap) begin
            w_holiday_nx = r_pending;
            w_pending_nx = 1'b0;
        end
        if (bus.holiday_set)
            w_holiday_nx = 1'b1;
        if (bus.holiday_next)
            w_pending_nx = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_holiday <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_holiday <= w_holiday_nx;
            r_pending <= w_pending_nx;
        end
    end

    assign bus.holiday = r_holiday;
`else
    logic w_unused_hol;
    assign w_unused_hol = bus.holiday_set ^ bus.holiday_next ^ w_hour_wrap;
    assign bus.holiday  = 1'b0;
`endif
endmodule

// File: tb/tb_commute_calendar.sv
// Randomized + directed check of commute_calendar against an absolute-tick-time model.
module tb_commute_calendar;
    localparam int TPH = 4;
    localparam int DS  = 7;
    localparam int DE  = 19;
    localparam int WEEK_TICKS = 7 * 24 * TPH;
`ifdef COMMUTE_CALENDAR_HOLIDAY_EN
    localparam bit HOL_EN = 1'b1;
`else
    localparam bit HOL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_err    = 0;
    int   n_txn    = 0;

    // Model: time kept as ticks since Sunday 00:00; hour/dow are derived from it.
    int   m_t    = 0;
    bit   m_hol  = 1'b0;
    bit   m_pend = 1'b0;

    commute_calendar_if bus ();

    commute_calendar #(.TICKS_PER_HOUR(TPH), .DAY_START(DS), .DAY_END(DE)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int m_hour();
        return (m_t / TPH) % 24;
    endfunction

    function automatic int m_dow();
        return m_t / (TPH * 24);
    endfunction

    task automatic check_all(input string tag);
        int h = m_hour();
        int d = m_dow();
        chk({tag, ".hour"},    32'(bus.hour),    32'(h));
        chk({tag, ".dow"},     32'(bus.dow),     32'(d));
        chk({tag, ".daytime"}, 32'(bus.daytime), 32'((h >= DS && h < DE) ? 1 : 0));
        chk({tag, ".weekday"}, 32'(bus.weekday), 32'((d >= 1 && d <= 5) ? 1 : 0));
        chk({tag, ".holiday"}, 32'(bus.holiday), 32'(HOL_EN ? m_hol : 1'b0));
    endtask

    task automatic model_edge(input bit tk, input bit ld, input int lh, input int ldw,
                              input bit hs, input bit hn);
        int  old_day = m_dow();
        bit  roll = 1'b0;
        if (ld) begin
            m_t = (((ldw == 7) ? 6 : ldw) * 24 + ((lh > 23) ? 23 : lh)) * TPH;
        end else if (tk) begin
            m_t  = (m_t + 1) % WEEK_TICKS;
            roll = (m_dow() != old_day);
        end
        if (roll) begin
            m_hol  = m_pend;
            m_pend = 1'b0;
        end
        if (hs) m_hol  = 1'b1;
        if (hn) m_pend = 1'b1;
    endtask

    task automatic model_reset();
        m_t = 0; m_hol = 1'b0; m_pend = 1'b0;
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input bit tk, input bit ld, input int lh, input int ldw,
                        input bit hs, input bit hn);
        bus.tick = tk; bus.load = ld;
        bus.load_hour = 5'(lh); bus.load_dow = 3'(ldw);
        bus.holiday_set = hs; bus.holiday_next = hn;
        @(posedge clk);
        model_edge(tk, ld, lh, ldw, hs, hn);
        #1;
        check_all("step");
        n_txn++;
        $display("txn %0d: tick=%0b load=%0b lh=%0d ld=%0d hs=%0b hn=%0b -> hour=%0d dow=%0d day=%0b wk=%0b hol=%0b",
                 n_txn, tk, ld, lh, ldw, hs, hn, bus.hour, bus.dow, bus.daytime, bus.weekday, bus.holiday);
        @(negedge clk);
        bus.tick = 1'b0; bus.load = 1'b0; bus.holiday_set = 1'b0; bus.holiday_next = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic load_time(input int lh, input int ldw);
        step(1'b0, 1'b1, lh, ldw, 1'b0, 1'b0);
    endtask

    task automatic async_reset(input string tag);
        #2 reset = 1'b1;
        model_reset();
        #1 check_all(tag);
        #1 reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        bus.tick = 1'b0; bus.load = 1'b0; bus.load_hour = '0; bus.load_dow = '0;
        bus.holiday_set = 1'b0; bus.holiday_next = 1'b0;
        #3 check_all("reset");
        @(negedge clk);
        reset = 1'b0;

        ticks(4);
        chk("first_hour", 32'(bus.hour), 32'd1);

        load_time(6, 3);
        ticks(4);
        chk("dawn_daytime", 32'(bus.daytime), 32'd1);
        ticks(48);
        chk("dusk_hour", 32'(bus.hour), 32'd19);

        load_time(23, 6);
        ticks(4);
        chk("week_wrap_dow", 32'(bus.dow), 32'd0);

        load_time(10, 2);
        step(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
        load_time(23, 2);
        ticks(4);
        chk("pending_holiday", 32'(bus.holiday), 32'(HOL_EN));
        load_time(23, 3);
        ticks(4);
        chk("holiday_cleared", 32'(bus.holiday), 32'd0);
        load_time(23, 4);
        ticks(3);
        step(1'b1, 1'b0, 0, 0, 1'b1, 1'b0);
        chk("set_on_rollover", 32'(bus.holiday), 32'(HOL_EN));
        load_time(9, 5);
        step(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
        load_time(23, 5);
        ticks(3);
        step(1'b1, 1'b0, 0, 0, 1'b0, 1'b1);
        ticks(96);

        step(1'b1, 1'b1, 5, 1, 1'b0, 1'b0);
        ticks(3);
        chk("load_clears_tickcnt", 32'(bus.hour), 32'd5);
        ticks(1);
        load_time(30, 7);
        chk("load_saturate", 32'(bus.hour), 32'd23);

        step(1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
        async_reset("async_reset");
        ticks(4);

        for (int i = 0; i < 600; i++) begin
            if (i == 300) async_reset("rand_reset");
            step(($urandom_range(0, 9) < 7), ($urandom_range(0, 49) == 0),
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
                 ($urandom_range(0, 29) == 0), ($urandom_range(0, 29) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/commute_calendar.md
# commute_calendar

Sequential time-of-week generator that produces the `daytime`, `weekday` and `holiday` condition bits consumed by the commute bus selector. It counts `tick` pulses into hours and days of week, tracks a holiday flag per day, and presents registered condition outputs that feed the selector directly. A synchronous load port sets the current time.

## Interface

- `TICKS_PER_HOUR`, default 4: `tick` pulses per hour; must be ≥ 1.
- `DAY_START`, default 7: first hour, inclusive, with `daytime` = 1.
- `DAY_END`, default 19: first hour, exclusive, with `daytime` = 0; requires `DAY_START` < `DAY_END` ≤ 24.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `tick` input 1: advances time by one tick when high for one cycle.
- `load` input 1: overwrites the current time with `load_hour`/`load_dow`.
- `load_hour` input 5: hour to load, 0..23.
- `load_dow` input 3: day of week to load, 0 = Sunday .. 6 = Saturday.
- `holiday_set` input 1: marks the current day as a holiday.
- `holiday_next` input 1: marks the following day as a holiday.
- `hour` output 5: current hour, 0..23.
- `dow` output 3: current day of week.
- `daytime` output 1: 1 when `DAY_START` ≤ `hour` < `DAY_END`.
- `weekday` output 1: 1 when `dow` is 1..5.
- `holiday` output 1: 1 when the current day is flagged as a holiday.

## Operation

- State consists of:
  - `tick_cnt` (width clog2(`TICKS_PER_HOUR`), minimum 1),
  - `hour`,
  - `dow`,
  - `holiday`,
  - `pending`, a flag for a holiday on the next day.
- Reset values: every counter and output is 0. This means `hour`=0, `dow`=0 (Sunday midnight), `daytime`=0, `weekday`=0, `holiday`=0, `pending`=0.
- Tick: when `tick_cnt` = `TICKS_PER_HOUR`-1, `tick_cnt` wraps to 0 and `hour` increments. Otherwise only `tick_cnt` increments.
- Hour wrap: `hour` 23 → 0 is a rollover. On rollover `dow` increments modulo 7 (6 → 0), `holiday` takes the value of `pending`, and `pending` clears.
- `holiday_set`: sets `holiday` to 1 for the current day. If it arrives in the same cycle as a rollover, it applies to the new day, so `holiday` = 1.
- `holiday_next`: sets `pending`. If it arrives in the same cycle as a rollover, it applies to the day after the new day, so `pending` = 1 after the edge.
- `load` has priority over `tick`. It sets `hour`/`dow` and clears `tick_cnt`. It does not change `holiday` or `pending`.
- An out-of-range load value is saturated: hour > 23 loads 23, dow = 7 loads 6.
- Condition outputs are registered. They are computed from next-state values, so they are always consistent with `hour`/`dow` on the same cycle.

## Timing

- Latency: a `tick` that completes an hour updates `hour`, `dow`, `daytime`, `weekday` and `holiday` on the same rising edge, with 1 cycle of visible latency.
- `load`, `holiday_set` and `holiday_next` are visible the cycle after the edge on which they are sampled.
- Inputs are sampled only on clock edges. `tick` held high for N cycles counts N ticks.
- Reset asserted mid-operation clears all state immediately (asynchronously) and discards any pending holiday. The first edge after deassertion uses normal rules.
- `load` and `holiday_set` in the same cycle: the time is loaded and the holiday flag is set.

## Configuration

- Macro: `COMMUTE_CALENDAR_HOLIDAY_EN`.
- Defined: holiday tracking operates as specified above.
- Undefined:
  - the `holiday` and `pending` registers are not built,
  - the `holiday` output is constant 0,
  - `holiday_set` and `holiday_next` are ignored,
  - all other behaviour is identical.

## Structure

- Shared package `commute_pkg` holds:
  - `HOURS_PER_DAY` = 24 and `DAYS_PER_WEEK` = 7,
  - the dow typedef `dow_t` (3 bits) with constants `SUNDAY`..`SATURDAY`,
  - the 2-bit bus color typedef shared with the selector.
- Sub-module: `wrap_counter` (parameter MOD; inputs `inc` and `load`; output `wrap`). It is instantiated three times, for the tick, hour and dow counters, and the counters are chained through `wrap`.

## Test plan

- Reset then 4 ticks (TPH=4) → `hour`=1, `dow`=0, `daytime`=0, `weekday`=0, `holiday`=0.
- `load` hour=6, dow=3, then 4 ticks → `hour`=7, `daytime` rises on that edge, `weekday`=1. A further 48 ticks → `hour`=19, `daytime`=0.
- `load` hour=23, dow=6, then 4 ticks → `hour`=0, `dow`=0, `weekday`=0.
- `holiday_next` at hour=10, followed by a rollover → `holiday`=1 for the entire new day, cleared at the next rollover. Drive `holiday_set` on the rollover cycle → `holiday`=1 on the new day.
- `load` and `tick` in the same cycle with hour=5 → `hour`=5, `tick_cnt`=0. `load_hour`=30 → `hour`=23.
- Assert `reset` asynchronously between edges while `holiday`=1 and `pending`=1 → all outputs 0 immediately. With the macro undefined, `holiday_set` → `holiday` stays 0.
